// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared branch constants, FSM state encoding and default datapath width
package riscv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        BR_IDLE  = 1'b0,
        BR_REDIR = 1'b1
    } br_state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - decode/fetch-facing signals of the branch resolve unit
interface branch_resolve_unit_if #(
    parameter int XLEN = riscv_pkg::XLEN_DEF
);
    logic            br_valid;
    logic            br_ready;
    logic            is_jal;
    logic [2:0]      br_funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            pc_ctr;
    logic [XLEN-1:0] pc_plus_four;
    logic [XLEN-1:0] pc_plus_offset;
    logic            redirect_valid;
    logic            fetch_ready;
    logic            flush;
    logic            illegal_br;

    modport master (
        output br_valid, is_jal, br_funct3, rs1_data, rs2_data, pc, imm, fetch_ready,
        input  br_ready, pc_ctr, pc_plus_four, pc_plus_offset, redirect_valid, flush, illegal_br
    );

    modport slave (
        input  br_valid, is_jal, br_funct3, rs1_data, rs2_data, pc, imm, fetch_ready,
        output br_ready, pc_ctr, pc_plus_four, pc_plus_offset, redirect_valid, flush, illegal_br
    );
endinterface

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational branch condition evaluation from funct3 and operands
module branch_cmp
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal
);
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves branches/JAL and holds taken redirects for fetch; BRANCH_STATS_EN adds counters
module branch_resolve_unit
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_resolve_unit_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] br_taken_cnt,
    output logic [CNT_W-1:0] br_total_cnt
`endif
);
    br_state_e state;
    logic      accept;
    logic      cmp_taken;
    logic      cmp_illegal;
    logic      take;
    logic      illegal;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3  (bus.br_funct3),
        .rs1     (bus.rs1_data),
        .rs2     (bus.rs2_data),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    // JAL ignores funct3 entirely, so it can never raise the illegal pulse.
    assign take    = bus.is_jal | cmp_taken;
    assign illegal = ~bus.is_jal & cmp_illegal;

    assign bus.br_ready = (state == BR_IDLE);
    assign accept       = bus.br_valid & bus.br_ready;
    assign bus.flush    = bus.redirect_valid & bus.fetch_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= BR_IDLE;
            bus.pc_ctr         <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.illegal_br     <= 1'b0;
            bus.pc_plus_four   <= '0;
            bus.pc_plus_offset <= '0;
        end else begin
            bus.illegal_br <= 1'b0;
            case (state)
                BR_IDLE: begin
                    if (accept) begin
                        bus.pc_plus_four   <= bus.pc + XLEN'(4);
                        bus.pc_plus_offset <= bus.pc + bus.imm;
                        bus.illegal_br     <= illegal;
                        bus.pc_ctr         <= take;
                        bus.redirect_valid <= take;
                        if (take) state <= BR_REDIR;
                    end
                end
                BR_REDIR: begin
                    if (bus.fetch_ready) begin
                        bus.pc_ctr         <= 1'b0;
                        bus.redirect_valid <= 1'b0;
                        state              <= BR_IDLE;
                    end
                end
                default: state <= BR_IDLE;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_taken_cnt <= '0;
            br_total_cnt <= '0;
        end else if (accept) begin
            if (br_total_cnt != '1)        br_total_cnt <= br_total_cnt + 1'b1;
            if (take && br_taken_cnt != '1) br_taken_cnt <= br_taken_cnt + 1'b1;
        end
    end
`endif
endmodule
